tt_harness_driver: RTL and testbench
====================================

# tt_harness_driver

Host-side sequencer for the byte-serial operand/result harness used by the team's TinyTapeout test designs. It accepts one wide operand word and one start pulse, then writes the operand into the design under test one byte per cycle through `ui_in`/`uio_in`. After the DUT's result register settles, it reads the result back one byte per cycle through `uo_out` and presents it as a parallel word with a done pulse. It sits on the FPGA/bench side of the chip pins and is the counterpart to the harness's byte-select input path and byte-select output mux.

## Interface

Parameters:
- `LOG2_BYTES_IN`, default 3: log2 of operand bytes; must be ≤ 4.
- `LOG2_BYTES_OUT`, default 2: log2 of result bytes; must be ≤ 2 (`sel_out` field is bits [5:4]).
- `SETTLE`, default 1: wait cycles between the last byte write and the first read; must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a transaction; sampled only in IDLE.
- `operand`, in, 8·2^LOG2_BYTES_IN: operand word; captured on the accepting edge.
- `busy`, out, 1: high from the accepting edge until `done`.
- `done`, out, 1: one-cycle pulse; `result` is valid from this cycle on.
- `result`, out, 8·2^LOG2_BYTES_OUT: last read result; holds its value until the next `done`.
- `dut_ui_in`, out, 8: drives DUT `ui_in` (data byte).
- `dut_uio_in`, out, 8: drives DUT `uio_in`.
  - `sel_in` is at bits [LOG2_BYTES_IN-1:0].
  - `sel_out` is at bits [4+LOG2_BYTES_OUT-1:4].
  - All other bits are 0.
- `dut_uo_out`, in, 8: DUT `uo_out` (selected result byte).

## Operation

- States: IDLE → LOAD → WAIT → READ → IDLE.
- All outputs are registered; nothing is combinational from an input.

Byte ordering:
- Operand byte i is `operand[8i+7:8i]`, written with `sel_in`=i.
- Result byte j is read with `sel_out`=j into `result[8j+7:8j]`.

States:
- **IDLE:** if `start`=1 at a clock edge, latch `operand`, set `busy`=1 and enter LOAD with index 0.
- **LOAD:** in cycle i, present byte i on `dut_ui_in` with `sel_in`=i. i runs from 0 to BYTES_IN-1, one byte per cycle. After i=BYTES_IN-1, enter WAIT.
- **WAIT:** lasts SETTLE cycles. `dut_ui_in` and `sel_in` hold byte BYTES_IN-1 and index BYTES_IN-1.
  - The DUT writes its selected byte on every edge, so this re-write is idempotent and required.
  - This hold also applies in READ and IDLE.
- **READ:** in cycle j, drive `sel_out`=j and capture `dut_uo_out` into result byte j at the end of that cycle. j runs from 0 to BYTES_OUT-1.
- **Completion:** on the edge that captures byte BYTES_OUT-1, enter IDLE, set `done`=1 and `busy`=0.
- **Back-to-back:** `start` during the `done` cycle is accepted. The next LOAD begins immediately.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- `operand` changes after acceptance do not affect the running transaction.
- `sel_out` holds its last value outside READ; it is 0 after reset.

Reset (`rst_n`=0, asynchronous, at any time including mid-transaction):
- State goes to IDLE; `busy`=0 and `done`=0.
- `result`=0, `dut_ui_in`=0 and `dut_uio_in`=0.
- The latched operand is cleared.
- A partially loaded DUT is not repaired; the next transaction reloads every byte.

## Timing

- Let E0 be the edge that accepts `start`.
- Operand byte i is captured by the DUT at edge E(i+1).
- The last operand byte is captured at E(BYTES_IN).
- The DUT result register updates at E(BYTES_IN+1).
- Result byte j is sampled at E(BYTES_IN+SETTLE+1+j).
- `done` is high in the cycle following E(BYTES_IN+SETTLE+BYTES_OUT).
- Latency from start to done is BYTES_IN+SETTLE+BYTES_OUT edges: 13 with the defaults.
- `busy` is high for exactly that many cycles.
- Throughput: one transaction per 13 cycles with the defaults (start held high).

## Test plan

All scenarios use defaults and a bench model of the ripple-adder DUT: x = operand[31:0], y = operand[63:32], 32-bit sum, carry-out dropped.

1. Reset values: hold `rst_n` low -> `busy`=0, `done`=0, `result`=0, `dut_ui_in`=0, `dut_uio_in`=0.
2. Single transaction: operand=0x00000001_00000001 -> `dut_uio_in` steps 0x00..0x07 during LOAD, then 0x07, 0x17, 0x27, 0x37 during READ; `done` in cycle 13; `result`=0x00000002.
3. Wrap-around: operand=0x00000001_FFFFFFFF -> `result`=0x00000000. Then operand=0x12345678_11111111 -> `result`=0x23456789.
4. Start while busy: pulse `start` at cycles 3 and 9 with a different operand -> both ignored; exactly one `done`; `result` matches the first operand.
5. Back-to-back: hold `start`=1 with operand A then B -> `done` pulses 13 cycles apart; each result matches its own operand; no idle gap.
6. Mid-operation reset: assert `rst_n`=0 during READ byte 1 -> outputs return to reset values asynchronously; no `done`. A following transaction with 0x00000003_00000004 -> `result`=0x00000007.

Source files
------------

// File: rtl/tt_harness_driver.sv
// rtl/tt_harness_driver.sv - byte-serial operand writer / result reader for the TinyTapeout harness
//
// Purpose: takes one wide operand plus a start pulse, streams the operand into
// the chip one byte per cycle (ui_in data, uio_in byte select), waits for the
// chip's result register to settle, reads the result back one byte per cycle
// through uo_out and presents it as a parallel word with a one-cycle done.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - transaction request, only looked at while idle
//   operand      - operand word, captured on the accepting edge
//   busy         - high from the accepting edge until done
//   done         - one-cycle pulse, result valid from this cycle on
//   result       - last complete result word
//   dut_ui_in    - data byte to the chip
//   dut_uio_in   - sel_in at [LOG2_BYTES_IN-1:0], sel_out at [4+:LOG2_BYTES_OUT]
//   dut_uo_out   - selected result byte from the chip
module tt_harness_driver #(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2,
    parameter int SETTLE         = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [8*(2**LOG2_BYTES_IN)-1:0]    operand,
    output logic                               busy,
    output logic                               done,
    output logic [8*(2**LOG2_BYTES_OUT)-1:0]   result,
    output logic [7:0]                         dut_ui_in,
    output logic [7:0]                         dut_uio_in,
    input  logic [7:0]                         dut_uo_out
);

    localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
    localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;
    localparam int WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [LOG2_BYTES_IN-1:0]  SEL_IN_LAST  = {LOG2_BYTES_IN{1'b1}};
    localparam logic [LOG2_BYTES_OUT-1:0] SEL_OUT_LAST = {LOG2_BYTES_OUT{1'b1}};
    localparam logic [WW-1:0]             WAIT_LAST    = WW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_READ
    } state_t;

    state_t                          state_q, state_d;
    logic [BYTES_IN-1:0][7:0]        operand_q, operand_d;
    logic [7:0]                      ui_q, ui_d;
    logic [LOG2_BYTES_IN-1:0]        sel_in_q, sel_in_d;
    logic [LOG2_BYTES_OUT-1:0]       sel_out_q, sel_out_d;
    logic [WW-1:0]                   wait_q, wait_d;
    logic [BYTES_OUT-1:0][7:0]       rd_buf_q, rd_buf_d;
    logic [BYTES_OUT-1:0][7:0]       result_q, result_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [BYTES_OUT-1:0][7:0]       rd_merged;
    logic                            accept;

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        ui_d      = ui_q;
        sel_in_d  = sel_in_q;
        sel_out_d = sel_out_q;
        wait_d    = wait_q;
        rd_buf_d  = rd_buf_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        accept    = 1'b0;

        // Partial bytes collect in rd_buf so result only changes on done.
        rd_merged            = rd_buf_q;
        rd_merged[sel_out_q] = dut_uo_out;

        case (state_q)
            S_IDLE: begin
                accept = start;
            end
            S_LOAD: begin
                if (sel_in_q == SEL_IN_LAST) begin
                    // Byte and index stay on the pins; the chip rewrites the
                    // same byte every edge, which is harmless.
                    state_d = S_WAIT;
                    wait_d  = '0;
                end else begin
                    sel_in_d = sel_in_q + 1'b1;
                    ui_d     = operand_q[sel_in_d];
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d   = S_READ;
                    sel_out_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_READ: begin
                rd_buf_d = rd_merged;
                if (sel_out_q == SEL_OUT_LAST) begin
                    result_d = rd_merged;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                    // Accepting on the completion edge gives back-to-back
                    // transactions with no idle cycle in between.
                    accept   = start;
                end else begin
                    sel_out_d = sel_out_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            operand_d = operand;
            ui_d      = operand[7:0];
            sel_in_d  = '0;
            busy_d    = 1'b1;
            state_d   = S_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            ui_q      <= '0;
            sel_in_q  <= '0;
            sel_out_q <= '0;
            wait_q    <= '0;
            rd_buf_q  <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            ui_q      <= ui_d;
            sel_in_q  <= sel_in_d;
            sel_out_q <= sel_out_d;
            wait_q    <= wait_d;
            rd_buf_q  <= rd_buf_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // uio_in is pure wiring of the two registered select fields.
    always_comb begin
        dut_uio_in                       = 8'h00;
        dut_uio_in[LOG2_BYTES_IN-1:0]    = sel_in_q;
        dut_uio_in[4 +: LOG2_BYTES_OUT]  = sel_out_q;
    end

    assign dut_ui_in = ui_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_tt_harness_driver.sv
// tb/tb_tt_harness_driver.sv - self-checking bench for tt_harness_driver against a ripple-adder chip model
module tb_tt_harness_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] operand = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic [7:0]  uo;

    always #5 clk = ~clk;

    tt_harness_driver #(
        .LOG2_BYTES_IN (3),
        .LOG2_BYTES_OUT(2),
        .SETTLE        (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operand   (operand),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dut_ui_in (ui),
        .dut_uio_in(uio),
        .dut_uo_out(uo)
    );

    // Chip model: byte-addressed operand register written every edge,
    // result register x + y (carry dropped), byte-select output mux.
    logic [7:0][7:0] chip_op  = '0;
    logic [3:0][7:0] chip_res = '0;

    always @(posedge clk) begin
        chip_op[uio[2:0]] <= ui;
        chip_res          <= 32'(chip_op[3:0]) + 32'(chip_op[7:4]);
    end

    assign uo = chip_res[uio[5:4]];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [63:0] op;
        logic [31:0] res;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Every sequence advances time only through tick, so the scoreboard sees each done.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            last_done = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_done: got result 0x%0h with no expected entry", result);
            end else begin
                chk("sb_result", {32'h0, result}, {32'h0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic run_txn(input logic [63:0] op, input logic [31:0] expv);
        int t0;
        int d0;
        d0 = done_cnt;
        start   = 1'b1;
        operand = op;
        exp_q.push_back(expv);
        tick();
        start   = 1'b0;
        operand = {$urandom(), $urandom()};
        t0 = cyc;
        while (done_cnt == d0 && (cyc - t0) < 40) tick();
        chk("latency", 64'(cyc - t0), 64'd13);
    endtask

    vec_t        vecs[6];
    logic [7:0]  uio_exp[14];

    initial begin
        int t0;
        int d0;
        int gaps;
        logic [63:0] opa;
        logic [63:0] opb;

        vecs[0] = '{op: 64'h00000001_00000001, res: 32'h00000002};
        vecs[1] = '{op: 64'h00000001_FFFFFFFF, res: 32'h00000000};
        vecs[2] = '{op: 64'h12345678_11111111, res: 32'h23456789};
        vecs[3] = '{op: 64'hFFFFFFFF_FFFFFFFF, res: 32'hFFFFFFFE};
        vecs[4] = '{op: 64'h80000000_80000000, res: 32'h00000000};
        vecs[5] = '{op: 64'h0F0F0F0F_10203040, res: 32'h1F2F3F4F};

        uio_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h07, 8'h07, 8'h17, 8'h27, 8'h37, 8'h37};

        // Reset values
        repeat (3) tick();
        chk("rst_busy",   {63'h0, busy}, 64'h0);
        chk("rst_done",   {63'h0, done}, 64'h0);
        chk("rst_result", {32'h0, result}, 64'h0);
        chk("rst_ui",     {56'h0, ui}, 64'h0);
        chk("rst_uio",    {56'h0, uio}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Single transaction with pin trace
        start   = 1'b1;
        operand = 64'h00000001_00000001;
        exp_q.push_back(32'h00000002);
        tick();
        start   = 1'b0;
        chk("trace_uio", {56'h0, uio}, {56'h0, uio_exp[0]});
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("trace_uio", {56'h0, uio}, {56'h0, uio_exp[k]});
            chk("trace_done", {63'h0, done}, {63'h0, (k == 13)});
        end
        chk("trace_result", {32'h0, result}, 64'h2);
        tick();

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].op, vecs[i].res);
            chk("vec_result", {32'h0, result}, {32'h0, vecs[i].res});
            repeat (2) tick();
            chk("vec_hold", {32'h0, result}, {32'h0, vecs[i].res});
        end

        // Start while busy is ignored
        opa = 64'h00000010_00000020;
        opb = 64'h55555555_55555555;
        d0 = done_cnt;
        start   = 1'b1;
        operand = opa;
        exp_q.push_back(32'h00000030);
        tick();
        start = 1'b0;
        t0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            tick();
            start = (k == 3 || k == 9);
            if (start) operand = opb;
        end
        start = 1'b0;
        chk("busy_ign_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("busy_ign_done_at", 64'(last_done - t0), 64'd13);
        chk("busy_ign_result", {32'h0, result}, 64'h30);
        chk("busy_ign_queue", 64'(exp_q.size()), 64'd0);

        // Back-to-back with start held
        opa = 64'h00000100_00000200;
        opb = 64'hAAAAAAAA_11111111;
        d0 = done_cnt;
        gaps = 0;
        start   = 1'b1;
        operand = opa;
        exp_q.push_back(32'h00000300);
        tick();
        t0 = cyc;
        operand = opb;
        exp_q.push_back(32'hBBBBBBBB);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k <= 25 && !busy) gaps++;
            if (k == 13) begin
                chk("b2b_busy_at_done", {63'h0, busy}, 64'h1);
                chk("b2b_first_result", {32'h0, result}, 64'h300);
                start = 1'b0;
            end
        end
        chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);
        chk("b2b_second_done_at", 64'(last_done - t0), 64'd26);
        chk("b2b_idle_gaps", 64'(gaps), 64'd0);
        chk("b2b_second_result", {32'h0, result}, 64'hBBBBBBBB);

        // Reset during READ byte 1
        d0 = done_cnt;
        start   = 1'b1;
        operand = 64'hDEADBEEF_01234567;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("mid_rst_pre_uio", {56'h0, uio}, 64'h17);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   {63'h0, busy}, 64'h0);
        chk("mid_rst_done",   {63'h0, done}, 64'h0);
        chk("mid_rst_result", {32'h0, result}, 64'h0);
        chk("mid_rst_ui",     {56'h0, ui}, 64'h0);
        chk("mid_rst_uio",    {56'h0, uio}, 64'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        run_txn(64'h00000003_00000004, 32'h00000007);
        chk("post_rst_result", {32'h0, result}, 64'h7);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched so far", n_cmp, n_err);
        $fatal(1);
    end

endmodule
